// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default timing constants for the PLL-driven reset sequencer.
package pll_reset_pkg;

  localparam int unsigned STABLE_CYCLES_DEF   = 4096;
  localparam int unsigned GAP_CYCLES_DEF      = 256;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 65536;
  localparam int unsigned LOCK_TIMEOUT_DEF    = 16777216;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    REL_PERIPH,
    RUN,
    BTN_HOLD
  } state_t;

  // Counter width able to hold (n-1) for the largest of three terminal counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer: waits for a stable PLL lock, releases peripheral then core reset,
// and re-sequences on lock loss or a debounced user reset button.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = STABLE_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES      = GAP_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT    = LOCK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       btn_rst_n,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       ready,
  output logic       lock_fault,
  output logic [7:0] relock_cnt
);

  localparam int unsigned TMR_W = cnt_width(STABLE_CYCLES, GAP_CYCLES, LOCK_TIMEOUT);
  localparam int unsigned DB_W  = cnt_width(DEBOUNCE_CYCLES, 1, 1);

  localparam logic [TMR_W-1:0] STABLE_M1 = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_M1    = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] LT_M1     = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [DB_W-1:0]  DB_M1     = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             lock_s, btn_s, btn_db;
  logic [DB_W-1:0]  db_cnt;
  logic [TMR_W-1:0] timer;
  state_t           state, state_nxt;

  sync2 #(.RST_VAL(1'b0)) u_lock_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock),  .q(lock_s));
  sync2 #(.RST_VAL(1'b1)) u_btn_sync  (.clk(clk), .rst_n(rst_n), .d(btn_rst_n), .q(btn_s));

  // Accept a new button level only after it has differed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_M1) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_nxt;
  end

  // Lock loss is tested before the button so it wins when both arrive together.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK:  if (lock_s) state_nxt = STABLE;
      STABLE: begin
        if      (!lock_s)             state_nxt = WAIT_LOCK;
        else if (!btn_db)             state_nxt = BTN_HOLD;
        else if (timer == STABLE_M1)  state_nxt = REL_PERIPH;
      end
      REL_PERIPH: begin
        if      (!lock_s)             state_nxt = WAIT_LOCK;
        else if (!btn_db)             state_nxt = BTN_HOLD;
        else if (timer == GAP_M1)     state_nxt = RUN;
      end
      RUN: begin
        if      (!lock_s)             state_nxt = WAIT_LOCK;
        else if (!btn_db)             state_nxt = BTN_HOLD;
      end
      BTN_HOLD:   if (btn_db) state_nxt = lock_s ? STABLE : WAIT_LOCK;
      default:    state_nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      lock_fault   <= 1'b0;
      relock_cnt   <= '0;
      rst_periph_n <= 1'b0;
      rst_core_n   <= 1'b0;
      ready        <= 1'b0;
    end else begin
      if (state_nxt != state)
        timer <= '0;
      else if (!(state == WAIT_LOCK && timer == LT_M1) && timer != '1)
        timer <= timer + 1'b1;

      if (state == WAIT_LOCK && timer == LT_M1)
        lock_fault <= 1'b1;

      if (state == RUN && !lock_s && relock_cnt != 8'hFF)
        relock_cnt <= relock_cnt + 8'd1;

      // Outputs decode the registered state, one cycle behind it.
      rst_periph_n <= (state == REL_PERIPH) || (state == RUN);
      rst_core_n   <= (state == RUN);
      ready        <= (state == RUN);
    end
  end

endmodule
